// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: register load enables, bubble inserts,
// RUN/DRAIN/HALTED halt sequence and a saturating stall counter. Optional macro: FORWARDING_EN.
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  idRs,
  input  logic [2:0]  idRt,
  input  logic        idRsValid,
  input  logic        idRtValid,
  input  logic        exRegWrite,
  input  logic        exMemRead,
  input  logic [2:0]  exWriteRegister,
  input  logic        memRegWrite,
  input  logic [2:0]  memWriteRegister,
  input  logic        exBranchTaken,
  input  logic        imemStall,
  input  logic        dmemStall,
  input  logic        idHalt,
  input  logic        wbHalt,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexWrite,
  output logic        exmemWrite,
  output logic        memwbWrite,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        memwbFlush,
  output logic        halted,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } stateT;

  stateT       stateR;
  stateT       stateNextS;
  logic        haltedR;
  logic [15:0] stallCountR;

  logic exMatchS;
  logic memMatchS;
  logic loadUseS;
  logic rawExS;
  logic rawMemS;
  logic dataHazardS;

  assign exMatchS  = (idRsValid && (idRs == exWriteRegister))  || (idRtValid && (idRt == exWriteRegister));
  assign memMatchS = (idRsValid && (idRs == memWriteRegister)) || (idRtValid && (idRt == memWriteRegister));
  assign rawExS    = exRegWrite && exMatchS;
  assign rawMemS   = memRegWrite && memMatchS;
  assign loadUseS  = exMemRead && rawExS;

`ifdef FORWARDING_EN
  assign dataHazardS = loadUseS;
`else
  // Without bypass paths only the register file's write-before-read covers WB.
  assign dataHazardS = rawExS || rawMemS;
`endif

  // Next-state and per-cycle enable/flush decode; reset forces everything low.
  always_comb begin
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    idexWrite  = 1'b0;
    exmemWrite = 1'b0;
    memwbWrite = 1'b0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    memwbFlush = 1'b0;
    stateNextS = stateR;
    if (rst) begin
      stateNextS = RUN;
    end else begin
      case (stateR)
        RUN: begin
          pcWrite    = 1'b1;
          ifidWrite  = 1'b1;
          idexWrite  = 1'b1;
          exmemWrite = 1'b1;
          memwbWrite = 1'b1;
          if (dmemStall) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
          end else if (exBranchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (dataHazardS) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
          end else if (imemStall) begin
            pcWrite   = 1'b0;
            ifidFlush = 1'b1;
            if (idHalt) begin
              stateNextS = DRAIN;
            end else begin
              stateNextS = RUN;
            end
          end else if (idHalt) begin
            stateNextS = DRAIN;
          end else begin
            stateNextS = RUN;
          end
        end
        DRAIN: begin
          ifidWrite  = 1'b1;
          idexWrite  = 1'b1;
          exmemWrite = 1'b1;
          memwbWrite = 1'b1;
          ifidFlush  = 1'b1;
          if (dmemStall) begin
            ifidWrite  = 1'b0;
            idexWrite  = 1'b0;
            exmemWrite = 1'b0;
            memwbFlush = 1'b1;
          end else begin
            memwbFlush = 1'b0;
          end
          if (wbHalt) begin
            stateNextS = HALTED;
          end else begin
            stateNextS = DRAIN;
          end
        end
        HALTED: begin
          stateNextS = HALTED;
        end
        default: begin
          stateNextS = RUN;
        end
      endcase
    end
  end

  // State, halted flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR      <= RUN;
      haltedR     <= 1'b0;
      stallCountR <= 16'd0;
    end else begin
      stateR  <= stateNextS;
      haltedR <= (stateNextS == HALTED);
      if ((stateR == RUN) && !pcWrite && (stallCountR != 16'hFFFF)) begin
        stallCountR <= stallCountR + 16'd1;
      end
    end
  end

  assign halted     = haltedR;
  assign stallCount = stallCountR;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller; expectations follow FORWARDING_EN.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  idRs, idRt, exWriteRegister, memWriteRegister;
  logic        idRsValid, idRtValid, exRegWrite, exMemRead, memRegWrite;
  logic        exBranchTaken, imemStall, dmemStall, idHalt, wbHalt;
  logic        pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
  logic        ifidFlush, idexFlush, memwbFlush, halted;
  logic [15:0] stallCount;
  logic [7:0]  ctrl;

  int errors = 0;
  int checks = 0;
  int expCount = 0;

  localparam logic [7:0] C_ZERO  = 8'b00000_000;
  localparam logic [7:0] C_NORM  = 8'b11111_000;
  localparam logic [7:0] C_DMEM  = 8'b00001_001;
  localparam logic [7:0] C_BR    = 8'b11111_110;
  localparam logic [7:0] C_HAZ   = 8'b00111_010;
  localparam logic [7:0] C_IMEM  = 8'b01111_100;
  localparam logic [7:0] C_DRAIN = 8'b01111_100;
  localparam logic [7:0] C_DRDM  = 8'b00001_101;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst),
    .idRs(idRs), .idRt(idRt), .idRsValid(idRsValid), .idRtValid(idRtValid),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exWriteRegister(exWriteRegister),
    .memRegWrite(memRegWrite), .memWriteRegister(memWriteRegister),
    .exBranchTaken(exBranchTaken), .imemStall(imemStall), .dmemStall(dmemStall),
    .idHalt(idHalt), .wbHalt(wbHalt),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .memwbWrite(memwbWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .memwbFlush(memwbFlush),
    .halted(halted), .stallCount(stallCount)
  );

  assign ctrl = {pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite, ifidFlush, idexFlush, memwbFlush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    idRs = 3'd0; idRt = 3'd0; idRsValid = 1'b0; idRtValid = 1'b0;
    exRegWrite = 1'b0; exMemRead = 1'b0; exWriteRegister = 3'd0;
    memRegWrite = 1'b0; memWriteRegister = 3'd0;
    exBranchTaken = 1'b0; imemStall = 1'b0; dmemStall = 1'b0;
    idHalt = 1'b0; wbHalt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idRs = 3'd3; idRsValid = 1'b1; exRegWrite = 1'b1; exMemRead = 1'b1; exWriteRegister = 3'd3;
    @(negedge clk);
    checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_ZERO); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
    checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", stallCount); end
    idle();
    rst = 1'b0;
    expCount = 0;
    #1;
    checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL reset_release_ctrl got=%b want=%b", ctrl, C_NORM); end
  endtask

  task automatic test_load_use();
    int base;
    base = expCount;
    @(negedge clk);
    idle();
    idRs = 3'd3; idRt = 3'd2; idRsValid = 1'b1; idRtValid = 1'b1;
    exRegWrite = 1'b1; exMemRead = 1'b1; exWriteRegister = 3'd3;
    #1;
    checks++; if (ctrl !== C_HAZ) begin errors++; $display("FAIL loaduse_ctrl got=%b want=%b", ctrl, C_HAZ); end
    expCount++;
    @(negedge clk);
    exRegWrite = 1'b0; exMemRead = 1'b0; exWriteRegister = 3'd0;
    memRegWrite = 1'b1; memWriteRegister = 3'd3;
    #1;
    checks++;
    if (ctrl !== (FWD ? C_NORM : C_HAZ)) begin
      errors++; $display("FAIL loaduse_second_ctrl got=%b want=%b", ctrl, FWD ? C_NORM : C_HAZ);
    end
    if (!FWD) expCount++;
    @(negedge clk);
    idle();
    checks++;
    if (stallCount !== 16'(expCount)) begin
      errors++; $display("FAIL loaduse_count got=%0d want=%0d (base %0d)", stallCount, expCount, base);
    end
    // register 0 compares like any other register
    idRt = 3'd0; idRtValid = 1'b1; exRegWrite = 1'b1; exMemRead = 1'b1; exWriteRegister = 3'd0;
    #1;
    checks++; if (ctrl !== C_HAZ) begin errors++; $display("FAIL loaduse_r0 got=%b want=%b", ctrl, C_HAZ); end
    expCount++;
    @(negedge clk);
    idRt = 3'd4; idRs = 3'd0; idRsValid = 1'b0;
    #1;
    checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL loaduse_invalid_src got=%b want=%b", ctrl, C_NORM); end
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL loaduse_r0_count got=%0d want=%0d", stallCount, expCount); end
  endtask

  task automatic test_raw_distance();
    logic [3:0] vec [3][3];
    int stalls;
    int want;
    // {exRegWrite, exDest=3/5, memRegWrite, memDest=3/6} per cycle, per distance
    vec[0][0] = 4'b1_0_0_0; vec[0][1] = 4'b0_0_1_0; vec[0][2] = 4'b0_0_0_0;
    vec[1][0] = 4'b1_1_1_0; vec[1][1] = 4'b0_0_0_0; vec[1][2] = 4'b0_0_0_0;
    vec[2][0] = 4'b1_1_1_1; vec[2][1] = 4'b0_0_0_0; vec[2][2] = 4'b0_0_0_0;
    for (int d = 0; d < 3; d++) begin
      stalls = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        idle();
        idRs = 3'd3; idRt = 3'd2; idRsValid = 1'b1; idRtValid = 1'b1;
        exRegWrite = vec[d][c][3]; exWriteRegister = vec[d][c][2] ? 3'd5 : 3'd3;
        memRegWrite = vec[d][c][1]; memWriteRegister = vec[d][c][0] ? 3'd6 : 3'd3;
        #1;
        if (pcWrite === 1'b0) stalls++;
      end
      want = FWD ? 0 : 2 - d;
      expCount += want;
      checks++; if (stalls !== want) begin errors++; $display("FAIL raw_dist%0d_stalls got=%0d want=%0d", d, stalls, want); end
    end
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL raw_count got=%0d want=%0d", stallCount, expCount); end
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    idle();
    idRs = 3'd3; idRsValid = 1'b1; exRegWrite = 1'b1; exMemRead = 1'b1; exWriteRegister = 3'd3;
    imemStall = 1'b1; exBranchTaken = 1'b1;
    #1;
    checks++; if (ctrl !== C_BR) begin errors++; $display("FAIL branch_prio_ctrl got=%b want=%b", ctrl, C_BR); end
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL branch_prio_count got=%0d want=%0d", stallCount, expCount); end
  endtask

  task automatic test_dmem_branch();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      exBranchTaken = 1'b1;
      dmemStall = (c < 3);
      #1;
      checks++;
      if (ctrl !== ((c < 3) ? C_DMEM : C_BR)) begin
        errors++; $display("FAIL dmem_branch_c%0d got=%b want=%b", c, ctrl, (c < 3) ? C_DMEM : C_BR);
      end
      if (c < 3) expCount++;
    end
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL dmem_count got=%0d want=%0d", stallCount, expCount); end
  endtask

  task automatic test_imem();
    @(negedge clk);
    idle();
    imemStall = 1'b1;
    #1;
    checks++; if (ctrl !== C_IMEM) begin errors++; $display("FAIL imem_ctrl got=%b want=%b", ctrl, C_IMEM); end
    expCount++;
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL imem_count got=%0d want=%0d", stallCount, expCount); end
  endtask

  task automatic test_halt();
    // halt blocked by a hazard stays in RUN
    @(negedge clk);
    idle();
    idHalt = 1'b1; idRs = 3'd1; idRsValid = 1'b1; exRegWrite = 1'b1; exMemRead = 1'b1; exWriteRegister = 3'd1;
    #1;
    checks++; if (ctrl !== C_HAZ) begin errors++; $display("FAIL halt_blocked_ctrl got=%b want=%b", ctrl, C_HAZ); end
    expCount++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctrl !== C_NORM) begin errors++; $display("FAIL halt_still_run got=%b want=%b", ctrl, C_NORM); end
    // halt alongside imemStall still enters DRAIN
    @(negedge clk);
    idHalt = 1'b1; imemStall = 1'b1;
    #1;
    checks++; if (ctrl !== C_IMEM) begin errors++; $display("FAIL halt_imem_ctrl got=%b want=%b", ctrl, C_IMEM); end
    expCount++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      exBranchTaken = (c == 0);
      dmemStall = (c == 1);
      wbHalt = (c == 2);
      #1;
      checks++;
      if (ctrl !== ((c == 1) ? C_DRDM : C_DRAIN)) begin
        errors++; $display("FAIL drain_c%0d got=%b want=%b", c, ctrl, (c == 1) ? C_DRDM : C_DRAIN);
      end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_halted_c%0d got=%b want=0", c, halted); end
    end
    @(negedge clk);
    idle();
    imemStall = 1'b1; idHalt = 1'b1;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_set got=%b want=1", halted); end
    checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL halted_ctrl got=%b want=%b", ctrl, C_ZERO); end
    repeat (3) @(negedge clk);
    checks++; if ((ctrl !== C_ZERO) || (halted !== 1'b1)) begin errors++; $display("FAIL halted_hold ctrl=%b halted=%b want=%b/1", ctrl, halted, C_ZERO); end
    checks++; if (stallCount !== 16'(expCount)) begin errors++; $display("FAIL halt_count got=%0d want=%0d", stallCount, expCount); end
    idle();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    idle();
    imemStall = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    idle();
    checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("FAIL saturate got=%h want=ffff", stallCount); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    idle();
    idHalt = 1'b1;
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctrl !== C_DRAIN) begin errors++; $display("FAIL middrain_pre got=%b want=%b", ctrl, C_DRAIN); end
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL middrain_rst_ctrl got=%b want=%b", ctrl, C_ZERO); end
    checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL middrain_rst_count got=%0d want=0", stallCount); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ((ctrl !== C_NORM) || (halted !== 1'b0)) begin errors++; $display("FAIL middrain_run ctrl=%b halted=%b want=%b/0", ctrl, halted, C_NORM); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_raw_distance();
    test_branch_priority();
    test_dmem_branch();
    test_imem();
    test_halt();
    test_reset();
    test_saturation();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
